// File: rtl/gf_mul_serial_if.sv
// -----------------------------------------------------------------------------
// gf_mul_serial_if
// Handshake/data bundle for the digit-serial GF(2^WIDTH) multiplier.
//
// Optional feature macro: GF_MUL_POLY_PORT_EN
//   When defined, the bundle also carries i_poly (low WIDTH bits of the
//   reduction polynomial, sampled together with the operands).
//
// Signals:
//   en         start request (master -> slave), accepted while o_ready=1
//   i_state_1  multiplicand a
//   i_state_2  multiplier b, scanned MSB-first
//   i_poly     reduction polynomial (GF_MUL_POLY_PORT_EN only)
//   o_ready    slave can accept en this cycle
//   o_state    product a*b mod P, held until the next completion
//   o_done     one-cycle pulse when o_state updates
// Modports: master (requester side), slave (multiplier side).
// -----------------------------------------------------------------------------
interface gf_mul_serial_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] i_state_1;
    logic [WIDTH-1:0] i_state_2;
    logic             o_ready;
    logic [WIDTH-1:0] o_state;
    logic             o_done;

`ifdef GF_MUL_POLY_PORT_EN
    logic [WIDTH-1:0] i_poly;

    modport master (
        output en, i_state_1, i_state_2, i_poly,
        input  o_ready, o_state, o_done
    );

    modport slave (
        input  en, i_state_1, i_state_2, i_poly,
        output o_ready, o_state, o_done
    );
`else
    modport master (
        output en, i_state_1, i_state_2,
        input  o_ready, o_state, o_done
    );

    modport slave (
        input  en, i_state_1, i_state_2,
        output o_ready, o_state, o_done
    );
`endif
endinterface

// File: rtl/gf_mul_serial.sv
// -----------------------------------------------------------------------------
// gf_mul_serial
// Digit-serial multiplier over GF(2^WIDTH). The multiplier b is consumed
// MSB-first, DIGIT bits per clock, using Horner's rule with reduction after
// every shift, so the accumulator never exceeds WIDTH bits. One product takes
// N = WIDTH/DIGIT clocks in CALC; a new request may be accepted in the same
// cycle o_done is high, giving one result every N+1 cycles.
//
// Optional feature macro: GF_MUL_POLY_PORT_EN
//   Defined  : the reduction polynomial comes from bus.i_poly, latched with
//              the operands when en is accepted (POLY is only a reset value).
//   Undefined: the fixed POLY parameter is used.
//
// Parameters:
//   WIDTH  field degree m (operand/result width)
//   POLY   low WIDTH bits of the irreducible polynomial (x^WIDTH implicit)
//   DIGIT  bits of b consumed per clock; must divide WIDTH
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; aborts an operation in flight
//   bus    gf_mul_serial_if slave modport (en/operands in, ready/result/done out)
// -----------------------------------------------------------------------------
module gf_mul_serial #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'h1B,
    parameter int               DIGIT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    gf_mul_serial_if.slave      bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
        $error("gf_mul_serial: DIGIT must divide WIDTH");
    end

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_done;
    logic             r_ready;
    logic [WIDTH-1:0] w_poly;

`ifdef GF_MUL_POLY_PORT_EN
    logic [WIDTH-1:0] r_poly;
    assign w_poly = r_poly;
`else
    assign w_poly = POLY;
`endif

    // Multiply by x with immediate reduction.
    function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] poly);
        logic [WIDTH-1:0] sh;
        sh = v << 1;
        return v[WIDTH-1] ? (sh ^ poly) : sh;
    endfunction

    // One Horner step per digit bit, MSB of the current digit first.
    // w_step[DIGIT] is the accumulator after this cycle's whole digit.
    logic [WIDTH-1:0] w_step [DIGIT+1];
    assign w_step[0] = r_acc;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_digit
        assign w_step[gi+1] = xtime(w_step[gi], w_poly)
                            ^ (r_b[WIDTH-1-gi] ? r_a : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
`ifdef GF_MUL_POLY_PORT_EN
            r_poly  <= POLY;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.en) begin
                        r_a     <= bus.i_state_1;
                        r_b     <= bus.i_state_2;
`ifdef GF_MUL_POLY_PORT_EN
                        r_poly  <= bus.i_poly;
`endif
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_acc <= w_step[DIGIT];
                    // Bring the next digit into the top bits.
                    r_b   <= r_b << DIGIT;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N - 1)) begin
                        r_out   <= w_step[DIGIT];
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_ready = r_ready;
    assign bus.o_state = r_out;
    assign bus.o_done  = r_done;

endmodule

// File: tb/tb_gf_mul_serial.sv
// -----------------------------------------------------------------------------
// tb_gf_mul_serial
// Four multiplier instances: WIDTH=8 with DIGIT=1/2/8 (AES polynomial) and
// WIDTH=4 with POLY=4'h3, DIGIT=1. Each request pushes {expected product,
// expected done cycle} into a per-instance queue; a negedge monitor pops and
// compares whenever o_done is seen. With GF_MUL_POLY_PORT_EN defined the
// run-time polynomial port is exercised as well.
// -----------------------------------------------------------------------------
module tb_gf_mul_serial;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    gf_mul_serial_if #(.WIDTH(8)) b0 ();
    gf_mul_serial_if #(.WIDTH(8)) b1 ();
    gf_mul_serial_if #(.WIDTH(8)) b2 ();
    gf_mul_serial_if #(.WIDTH(4)) b3 ();

    gf_mul_serial #(.WIDTH(8), .POLY(8'h1B), .DIGIT(1)) u_w8d1 (.clk(clk), .rst_n(rst_n), .bus(b0));
    gf_mul_serial #(.WIDTH(8), .POLY(8'h1B), .DIGIT(2)) u_w8d2 (.clk(clk), .rst_n(rst_n), .bus(b1));
    gf_mul_serial #(.WIDTH(8), .POLY(8'h1B), .DIGIT(8)) u_w8d8 (.clk(clk), .rst_n(rst_n), .bus(b2));
    gf_mul_serial #(.WIDTH(4), .POLY(4'h3),  .DIGIT(1)) u_w4d1 (.clk(clk), .rst_n(rst_n), .bus(b3));

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: LSB-first shift-and-add over GF(2^w).
    function automatic logic [7:0] gf_ref(int w, logic [7:0] poly, logic [7:0] a, logic [7:0] b);
        logic [7:0] r;
        logic [7:0] m;
        logic [7:0] x;
        logic       hi;
        r = '0;
        x = a;
        m = 8'((1 << w) - 1);
        for (int i = 0; i < w; i++) begin
            if (b[i]) r = r ^ x;
            hi = x[w-1];
            x  = (x << 1) & m;
            if (hi) x = x ^ poly;
        end
        return r;
    endfunction

    function automatic int lat_of(int sel);
        case (sel)
            0: return 8;
            1: return 4;
            2: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic rdy_of(int sel);
        case (sel)
            0: return b0.o_ready;
            1: return b1.o_ready;
            2: return b2.o_ready;
            default: return b3.o_ready;
        endcase
    endfunction

    function automatic int qsize(int sel);
        case (sel)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    // Raise en with operands for one cycle, without waiting for o_ready.
    task automatic drive(int sel, logic [7:0] a, logic [7:0] b, logic [7:0] poly);
        case (sel)
            0: begin b0.en = 1'b1; b0.i_state_1 = a; b0.i_state_2 = b; end
            1: begin b1.en = 1'b1; b1.i_state_1 = a; b1.i_state_2 = b; end
            2: begin b2.en = 1'b1; b2.i_state_1 = a; b2.i_state_2 = b; end
            default: begin b3.en = 1'b1; b3.i_state_1 = a[3:0]; b3.i_state_2 = b[3:0]; end
        endcase
`ifdef GF_MUL_POLY_PORT_EN
        case (sel)
            0: b0.i_poly = poly;
            1: b1.i_poly = poly;
            2: b2.i_poly = poly;
            default: b3.i_poly = poly[3:0];
        endcase
`else
        if (poly != 8'h1B && sel != 3) $info("poly %0h only used with port enabled", poly);
`endif
        @(negedge clk);
        case (sel)
            0: b0.en = 1'b0;
            1: b1.en = 1'b0;
            2: b2.en = 1'b0;
            default: b3.en = 1'b0;
        endcase
    endtask

    // Wait (bounded) for o_ready, issue a request and record its expectation.
    task automatic start(int sel, logic [7:0] a, logic [7:0] b, logic [7:0] exp,
                         logic push, logic [7:0] poly, output int dcyc);
        int   n;
        logic rdy;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            rdy = rdy_of(sel);
            n++;
        end while (!rdy && n < 200);
        check($sformatf("ready_wait_dut%0d", sel), 32'(rdy), 32'd1);
        dcyc  = cyc;
        e.val = exp;
        e.cyc = cyc + 1 + lat_of(sel);
        if (push) begin
            case (sel)
                0: q0.push_back(e);
                1: q1.push_back(e);
                2: q2.push_back(e);
                default: q3.push_back(e);
            endcase
        end
        $display("req dut%0d a=%0h b=%0h expect=%0h at cycle %0d", sel, a, b, exp, e.cyc);
        drive(sel, a, b, poly);
    endtask

    task automatic mon(int sel, logic [7:0] v);
        exp_t e;
        int   sz;
        sz = qsize(sel);
        check($sformatf("done_expected_dut%0d", sel), 32'(sz != 0), 32'd1);
        if (sz == 0) return;
        case (sel)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            2: e = q2.pop_front();
            default: e = q3.pop_front();
        endcase
        $display("done dut%0d result=%0h expect=%0h cycle=%0d", sel, v, e.val, cyc);
        check($sformatf("result_dut%0d", sel), 32'(v), 32'(e.val));
        check($sformatf("latency_dut%0d", sel), 32'(cyc), 32'(e.cyc));
    endtask

    task automatic wait_drain(int sel);
        int n;
        n = 0;
        while ((qsize(sel) != 0 || !rdy_of(sel)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("drain_dut%0d", sel), 32'(qsize(sel)), 32'd0);
    endtask

    always @(negedge clk) if (b0.o_done) mon(0, b0.o_state);
    always @(negedge clk) if (b1.o_done) mon(1, b1.o_state);
    always @(negedge clk) if (b2.o_done) mon(2, b2.o_state);
    always @(negedge clk) if (b3.o_done) mon(3, {4'h0, b3.o_state});

    initial begin
        int d1, d2, dx;
        logic [7:0] ra, rb;

        b0.en = 0; b0.i_state_1 = '0; b0.i_state_2 = '0;
        b1.en = 0; b1.i_state_1 = '0; b1.i_state_2 = '0;
        b2.en = 0; b2.i_state_1 = '0; b2.i_state_2 = '0;
        b3.en = 0; b3.i_state_1 = '0; b3.i_state_2 = '0;
`ifdef GF_MUL_POLY_PORT_EN
        b0.i_poly = 8'h1B; b1.i_poly = 8'h1B; b2.i_poly = 8'h1B; b3.i_poly = 4'h3;
`endif

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready_d1", 32'(b0.o_ready), 32'd1);
        check("rst_done_d1",  32'(b0.o_done),  32'd0);
        check("rst_state_d1", 32'(b0.o_state), 32'd0);
        check("rst_ready_w4", 32'(b3.o_ready), 32'd1);
        check("rst_state_w4", 32'(b3.o_state), 32'd0);
        rst_n = 1'b1;

        // 0x26*0x9E, ready low for all 8 CALC cycles.
        start(0, 8'h26, 8'h9E, 8'h2F, 1'b1, 8'h1B, dx);
        check("busy_0", 32'(b0.o_ready), 32'd0);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("busy_%0d", i), 32'(b0.o_ready), 32'd0);
        end
        wait_drain(0);

        // Back-to-back: second request in the o_done cycle.
        start(0, 8'h57, 8'h83, 8'hC1, 1'b1, 8'h1B, d1);
        start(0, 8'h57, 8'h13, 8'hFE, 1'b1, 8'h1B, d2);
        check("b2b_gap", 32'(d2 - d1), 32'd9);
        start(0, 8'h53, 8'hCA, 8'h01, 1'b1, 8'h1B, dx);
        wait_drain(0);

        // Other digit sizes and zero operand (full latency).
        start(1, 8'h57, 8'h83, 8'hC1, 1'b1, 8'h1B, dx);
        start(2, 8'h57, 8'h83, 8'hC1, 1'b1, 8'h1B, dx);
        start(1, 8'h00, 8'hFF, 8'h00, 1'b1, 8'h1B, dx);
        start(2, 8'h00, 8'hFF, 8'h00, 1'b1, 8'h1B, dx);
        start(0, 8'h00, 8'hFF, 8'h00, 1'b1, 8'h1B, dx);
        wait_drain(0); wait_drain(1); wait_drain(2);

        // Small field x^4+x+1.
        start(3, 8'h07, 8'h0B, 8'h04, 1'b1, 8'h03, dx);
        start(3, 8'h01, 8'h0F, 8'h0F, 1'b1, 8'h03, dx);
        wait_drain(3);

        // Pseudo-random operands against the reference model.
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            start(0, ra, rb, gf_ref(8, 8'h1B, ra, rb), 1'b1, 8'h1B, dx);
            start(1, ra, rb, gf_ref(8, 8'h1B, ra, rb), 1'b1, 8'h1B, dx);
            start(2, ra, rb, gf_ref(8, 8'h1B, ra, rb), 1'b1, 8'h1B, dx);
            start(3, ra, rb, gf_ref(4, 8'h03, ra & 8'h0F, rb & 8'h0F), 1'b1, 8'h03, dx);
            wait_drain(0); wait_drain(1); wait_drain(2); wait_drain(3);
        end

        // en mid-CALC with new operands is ignored.
        start(0, 8'h57, 8'h83, 8'hC1, 1'b1, 8'h1B, dx);
        @(negedge clk);
        drive(0, 8'hFF, 8'hFF, 8'h1B);
        b0.i_state_1 = 8'h12;
        b0.i_state_2 = 8'h34;
        wait_drain(0);

        // Reset mid-CALC aborts: no done, result cleared.
        start(0, 8'h26, 8'h9E, 8'h2F, 1'b0, 8'h1B, dx);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_state", 32'(b0.o_state), 32'd0);
        check("abort_ready", 32'(b0.o_ready), 32'd1);
        check("abort_done",  32'(b0.o_done),  32'd0);
        repeat (12) @(negedge clk);
        start(0, 8'h57, 8'h13, 8'hFE, 1'b1, 8'h1B, dx);
        wait_drain(0);

`ifdef GF_MUL_POLY_PORT_EN
        start(0, 8'h26, 8'h9E, 8'h2F, 1'b1, 8'h1B, dx);
        start(0, 8'h02, 8'h80, 8'h1D, 1'b1, 8'h1D, dx);
        wait_drain(0);
        start(0, 8'h02, 8'h80, 8'h1D, 1'b1, 8'h1D, dx);
        b0.i_poly = 8'h1B;
        @(negedge clk);
        b0.i_poly = 8'h00;
        wait_drain(0);
        b0.i_poly = 8'h1B;
`endif

        repeat (5) @(negedge clk);
        check("final_q0", 32'(q0.size()), 32'd0);
        check("final_q1", 32'(q1.size()), 32'd0);
        check("final_q2", 32'(q2.size()), 32'd0);
        check("final_q3", 32'(q3.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf_mul_serial.md
Name: gf_mul_serial

Overview:
Parametrised digit-serial multiplier over GF(2^WIDTH) with a configurable reduction polynomial. It generalises the fixed 8-bit AES field multiplier to any field width and to 1..WIDTH bits processed per cycle. It uses an en/ready/done handshake and supports back-to-back operations. It sits beside the AES datapath (MixColumns and key-schedule helpers) and is reusable for GHASH-style or small-field arithmetic.

Parameters:
WIDTH, 8, field degree m; operand and result width in bits.
POLY, 8'h1B, low WIDTH bits of the irreducible polynomial; the x^WIDTH term is implicit. The default is the AES polynomial x^8+x^4+x^3+x+1.
DIGIT, 1, bits of i_state_2 consumed per cycle. Must divide WIDTH; any other value is an elaboration error.

Ports:
clk  input  1  clock; all logic acts on the rising edge.
rst_n  input  1  synchronous active-low reset.
en  input  1  start request; accepted only when o_ready=1.
i_state_1  input  WIDTH  multiplicand a.
i_state_2  input  WIDTH  multiplier b; scanned MSB-first.
o_ready  output  1  block can accept en this cycle.
o_state  output  WIDTH  product a*b mod P; held until the next completion.
o_done  output  1  one-cycle pulse when o_state updates.

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous, active-low (rst_n).
- Reset values: o_state=0, o_done=0, o_ready=1, state=IDLE, acc=0, digit counter=0, latched operands=0.
- Reset mid-operation aborts the multiply. No o_done is produced, and o_state returns to 0.
- N = WIDTH/DIGIT.
- States: IDLE and CALC.
- IDLE, o_ready=1. If en=1 at an edge:
  - latch a and b into internal registers;
  - set acc=0 and cnt=0;
  - go to CALC.
- IDLE with en=0: hold all registers.
- CALC, o_ready=0. Each edge performs one digit step:
  - take d = top DIGIT bits of the remaining b;
  - repeat DIGIT times, MSB of d first: acc = xtime(acc) ^ (bit ? a : 0);
  - xtime(v) = (v<<1) truncated to WIDTH bits, XOR POLY if v[WIDTH-1] was 1;
  - shift b left by DIGIT and increment cnt.
- On the N-th CALC edge:
  - o_state <= final acc;
  - o_done <= 1;
  - state returns to IDLE, so o_ready=1 in the following cycle.
- o_done is 1 for exactly the cycle after the final edge and is 0 otherwise.
- Latency: en sampled at edge E gives o_done/o_state visible after edge E+N. Examples: 8 cycles for WIDTH=8, DIGIT=1; 1 cycle for DIGIT=WIDTH.
- Back-to-back: en=1 during the o_done cycle is accepted, so throughput is one result every N+1 cycles.
- en while o_ready=0 is ignored and not queued. Operand changes during CALC have no effect.
- Zero operand gives a 0 result with the full latency; there is no early exit.
- All arithmetic is carry-less XOR. No product term exceeds WIDTH bits because reduction happens at every shift.

Optional Feature:
GF_MUL_POLY_PORT_EN
- Defined:
  - adds input port i_poly [WIDTH-1:0], low bits of the reduction polynomial;
  - i_poly is latched together with the operands when en is accepted and is used for the whole operation;
  - the POLY parameter is ignored;
  - changes to i_poly during CALC have no effect.
- Undefined: the port is absent and the fixed POLY parameter is used.

Test Plan:
1. WIDTH=8, DIGIT=1, POLY=8'h1B; reset, then en pulse with a=0x26, b=0x9E -> o_done after exactly 8 edges, o_state=0x2F; o_ready low for 8 cycles.
2. WIDTH=8, DIGIT=1: a=0x57, b=0x83 -> 0xC1. Back-to-back en in the o_done cycle with a=0x57, b=0x13 -> 0xFE after another 8 cycles. Also a=0x53, b=0xCA -> 0x01.
3. WIDTH=8, DIGIT=2 and DIGIT=8 with a=0x57, b=0x83 -> 0xC1 after 4 and 1 cycles respectively. a=0x00, b=0xFF -> 0x00 with full latency.
4. WIDTH=4, POLY=4'h3, DIGIT=1: a=0x7, b=0xB -> 0x4 after 4 cycles. a=0x1, b=0xF -> 0xF.
5. Ignored en and reset abort:
   - en re-pulsed with new operands mid-CALC -> ignored, original product delivered;
   - rst_n=0 for one edge mid-CALC -> o_state=0, o_done never pulses, o_ready=1 next cycle.
6. With GF_MUL_POLY_PORT_EN, WIDTH=8: i_poly=8'h1B, a=0x26, b=0x9E -> 0x2F. i_poly=8'h1D, a=0x02, b=0x80 -> 0x1D. Toggling i_poly mid-CALC -> no effect on the result.
